// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester and RAM-side signals of the RAM port arbiter.
//
// Handshake: a requester raises reqX with weX/addrX/wdataX and holds all four
// stable until it sees gntX=1. gntX is a one-cycle pulse meaning "your command
// is on the RAM port this cycle". Dropping reqX before gntX withdraws the
// command. A read returns one-cycle rvalidX one cycle after gntX, and rdata is
// valid in that cycle.
interface ram_port_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 8
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          gnt0;
    logic          rvalid0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          gnt1;
    logic          rvalid1;

    logic [DW-1:0] rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic [DW-1:0] ram_q;

    // Arbiter side.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  ram_q,
        output gnt0, rvalid0, gnt1, rvalid1,
        output rdata, ram_we, ram_addr, ram_data
    );

    // Requester / RAM side.
    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output ram_q,
        input  gnt0, rvalid0, gnt1, rvalid1,
        input  rdata, ram_we, ram_addr, ram_data
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM (registered read)
// between two req/gnt requesters, issuing at most one command per cycle.
//
// Build option RAM_ARB_FIXED_PRIO_EN: when defined, requester 0 wins whenever
// it is eligible (fixed priority). When undefined, ties are broken
// round-robin using the last-served pointer.
module ram_port_arbiter #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    ram_port_arbiter_if.slave bus
);

    // A requester granted this cycle is ignored until the next cycle, which
    // is why a lone continuous requester is served every other cycle.
    logic elig0;
    logic elig1;
    logic win0;
    logic win1;

    logic          gnt0_q,    gnt0_d;
    logic          gnt1_q,    gnt1_d;
    logic          last_q,    last_d;     // last requester served
    logic          ram_we_q,  ram_we_d;
    logic [AW-1:0] addr_q,    addr_d;
    logic [DW-1:0] data_q,    data_d;
    logic          rvalid0_q, rvalid0_d;
    logic          rvalid1_q, rvalid1_d;

    // Winner selection from the current requests.
    always_comb begin
        elig0 = bus.req0 & ~gnt0_q;
        elig1 = bus.req1 & ~gnt1_q;
`ifdef RAM_ARB_FIXED_PRIO_EN
        win0  = elig0;
        win1  = elig1 & ~elig0;
`else
        // On a tie, serve whoever was not served last (last_q=1 favours 0).
        win0  = elig0 & (~elig1 | last_q);
        win1  = elig1 & ~win0;
`endif
    end

    // Next-state: load the winner's command; otherwise hold address/data.
    always_comb begin
        gnt0_d    = win0;
        gnt1_d    = win1;
        last_d    = last_q;
        ram_we_d  = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        // The RAM samples the command issued this cycle; its q is valid next.
        rvalid0_d = gnt0_q & ~ram_we_q;
        rvalid1_d = gnt1_q & ~ram_we_q;
        if (win0) begin
            ram_we_d = bus.we0;
            addr_d   = bus.addr0;
            data_d   = bus.wdata0;
            last_d   = 1'b0;
        end else if (win1) begin
            ram_we_d = bus.we1;
            addr_d   = bus.addr1;
            data_d   = bus.wdata1;
            last_d   = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            last_q    <= 1'b1;
            ram_we_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            last_q    <= last_d;
            ram_we_q  <= ram_we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    assign bus.gnt0     = gnt0_q;
    assign bus.gnt1     = gnt1_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    // A command registered before reset must not reach the RAM while rst is
    // high, so the write enable is masked combinationally.
    assign bus.ram_we   = ram_we_q & ~rst;
    assign bus.ram_addr = addr_q;
    assign bus.ram_data = data_q;
    assign bus.rdata    = bus.ram_q;

endmodule
